// File: rtl/intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intr_ctrl_pkg
// Shared constants for the interrupt controller: default register window base,
// register offsets within the window and the controller state encodings.
// No ports.
// -----------------------------------------------------------------------------
package intr_ctrl_pkg;

   // Default base address of the three-word register window.
   localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_0010;

   // Byte offsets of the registers relative to BASE.
   localparam logic [31:0] OFF_PENDING = 32'd0;
   localparam logic [31:0] OFF_MASK    = 32'd4;
   localparam logic [31:0] OFF_STATUS  = 32'd8;

   // Controller states; these values are visible to software in STATUS[4:3].
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   // Width of a source index (up to 8 sources).
   localparam int ID_W = 3;

endpackage

// File: rtl/intr_ctrl_if.sv
// -----------------------------------------------------------------------------
// intr_ctrl_if
// Data-memory side bus used to reach the interrupt controller registers.
//   address   : byte address of the access
//   wr_data   : store data
//   MemRead   : load strobe
//   MemWrite  : store strobe
//   rd_data   : register read data, 0 when the window is not selected
//   addr_hit  : access strobe present and address inside the register window
// The CPU side uses the master modport, the controller the slave modport.
// -----------------------------------------------------------------------------
interface intr_ctrl_if;

   logic [31:0] address;
   logic [31:0] wr_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] rd_data;
   logic        addr_hit;

   modport master (
      output address,
      output wr_data,
      output MemRead,
      output MemWrite,
      input  rd_data,
      input  addr_hit
   );

   modport slave (
      input  address,
      input  wr_data,
      input  MemRead,
      input  MemWrite,
      output rd_data,
      output addr_hit
   );

endinterface

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: returns the lowest set index of i_req (index 0 has
// the highest priority) and a flag telling whether any bit was set.
//   i_req   : N request bits
//   o_idx   : index of the winning request, 0 when none is set
//   o_valid : at least one request bit is set
// -----------------------------------------------------------------------------
module irq_prio_enc
   import intr_ctrl_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    i_req,
   output logic [ID_W-1:0] o_idx,
   output logic            o_valid
);

   // Scan from the top down so the last hit, the lowest index, wins.
   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = ID_W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Memory-mapped interrupt controller. Detects rising edges on the raw request
// lines, records them in PENDING, and raises InterruptOut toward coprocessor 0
// for the highest-priority pending, unmasked source. One interrupt is serviced
// at a time; new edges only accumulate until the handler returns with ERET.
//
// Ports
//   clock          : system clock, all state on the rising edge
//   reset          : synchronous active-high reset
//   irq_src        : raw interrupt request lines (rising-edge sensitive)
//   TakenInterrupt : coprocessor 0 has taken the asserted interrupt
//   ERET           : return from exception decoded
//   InterruptOut   : registered interrupt request, high only in ASSERT
//   active_id      : index of the source being asserted or serviced
//   bus            : register access bus (slave side)
//
// Register map (byte offsets from BASE)
//   +0 PENDING  R, write-1-to-clear
//   +4 MASK     R/W, bits N_SRC-1:0
//   +8 STATUS   R, {27'b0, state[1:0], active_id}; writes ignored
// -----------------------------------------------------------------------------
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int          N_SRC = 4,
   parameter logic [31:0] BASE  = DEFAULT_BASE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             TakenInterrupt,
   input  logic             ERET,
   output logic             InterruptOut,
   output logic [ID_W-1:0]  active_id,
   intr_ctrl_if.slave       bus
);

   localparam logic [N_SRC-1:0] W_ONE = N_SRC'(1);

   // State
   logic [N_SRC-1:0] r_irq_prev;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_mask;
   logic [1:0]       r_state;
   logic [ID_W-1:0]  r_active_id;
   logic             r_int_out;

   // Address decode
   logic [31:0]      w_offset;
   logic             w_sel_pend;
   logic             w_sel_mask;
   logic             w_sel_status;
   logic             w_in_win;
   logic             w_wr;

   // Next-state terms
   logic [N_SRC-1:0] w_edge;
   logic [N_SRC-1:0] w_w1c;
   logic [N_SRC-1:0] w_active_oh;
   logic [N_SRC-1:0] w_taken_clr;
   logic [N_SRC-1:0] w_pending_nxt;
   logic [N_SRC-1:0] w_mask_nxt;
   logic [N_SRC-1:0] w_req;
   logic             w_taken;
   logic [ID_W-1:0]  w_enc_idx;
   logic             w_enc_valid;
   logic [1:0]       w_state_nxt;
   logic             w_load_id;

   // Store data above the implemented source bits is intentionally ignored.
   logic             w_unused_wr;
   assign w_unused_wr = ^bus.wr_data[31:N_SRC];

   // ---------------------------------------------------------------------------
   // Address decode. The offset compare is exact, so any address outside
   // BASE..BASE+8 or between the three words misses; the explicit alignment
   // test also keeps a misaligned BASE from producing a hit.
   // ---------------------------------------------------------------------------
   assign w_offset     = bus.address - BASE;
   assign w_sel_pend   = (w_offset == OFF_PENDING);
   assign w_sel_mask   = (w_offset == OFF_MASK);
   assign w_sel_status = (w_offset == OFF_STATUS);
   assign w_in_win     = (bus.address[1:0] == 2'b00) &
                         (w_sel_pend | w_sel_mask | w_sel_status);
   assign w_wr         = bus.MemWrite & w_in_win;

   assign bus.addr_hit = (bus.MemRead | bus.MemWrite) & w_in_win;

   // Combinational read: data is valid in the same cycle as MemRead.
   always_comb begin
      bus.rd_data = '0;
      if (bus.MemRead && w_in_win) begin
         if (w_sel_pend) begin
            bus.rd_data = 32'(r_pending);
         end else if (w_sel_mask) begin
            bus.rd_data = 32'(r_mask);
         end else begin
            bus.rd_data = {27'b0, r_state, r_active_id};
         end
      end
   end

   // ---------------------------------------------------------------------------
   // PENDING / MASK next values
   // ---------------------------------------------------------------------------
   assign w_edge      = irq_src & ~r_irq_prev;
   assign w_w1c       = (w_wr && w_sel_pend) ? bus.wr_data[N_SRC-1:0] : '0;
   assign w_mask_nxt  = (w_wr && w_sel_mask) ? bus.wr_data[N_SRC-1:0] : r_mask;
   assign w_active_oh = W_ONE << r_active_id;
   assign w_taken     = (r_state == ST_ASSERT) & TakenInterrupt;
   assign w_taken_clr = w_taken ? w_active_oh : '0;

   // Edges are OR-ed in last so a same-cycle edge beats both the software
   // clear and the clear on interrupt acceptance.
   assign w_pending_nxt = (r_pending & ~w_w1c & ~w_taken_clr) | w_edge;

   assign w_req = r_pending & r_mask;

   irq_prio_enc #(
      .N       (N_SRC)
   ) u_prio_enc (
      .i_req   (w_req),
      .o_idx   (w_enc_idx),
      .o_valid (w_enc_valid)
   );

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_load_id   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_enc_valid) begin
               w_state_nxt = ST_ASSERT;
               w_load_id   = 1'b1;
            end
         end
         ST_ASSERT: begin
            // Acceptance has priority over a same-cycle withdrawal. Withdrawal
            // looks at the post-update PENDING/MASK so the request drops in the
            // cycle right after software clears it.
            if (w_taken) begin
               w_state_nxt = ST_SERVICE;
            end else if ((w_pending_nxt & w_mask_nxt & w_active_oh) == '0) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (ERET) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_irq_prev  <= '0;
         r_pending   <= '0;
         r_mask      <= '0;
         r_state     <= ST_IDLE;
         r_active_id <= '0;
         r_int_out   <= 1'b0;
      end else begin
         r_irq_prev  <= irq_src;
         r_pending   <= w_pending_nxt;
         r_mask      <= w_mask_nxt;
         r_state     <= w_state_nxt;
         if (w_load_id) begin
            r_active_id <= w_enc_idx;
         end
         r_int_out   <= (w_state_nxt == ST_ASSERT);
      end
   end

   assign InterruptOut = r_int_out;
   assign active_id    = r_active_id;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of interrupt sources (1..8).
REQ-002 SHALL have parameter BASE, default 32'hFFFF0010, base address of the register window.
REQ-003 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port irq_src  input  N_SRC  raw interrupt request lines, rising-edge sensitive.
REQ-006 SHALL have port address  input  32  data-memory byte address.
REQ-007 SHALL have port wr_data  input  32  store data.
REQ-008 SHALL have ports MemRead, MemWrite  input  1 each  data-memory access strobes.
REQ-009 SHALL have ports TakenInterrupt, ERET  input  1 each  from coprocessor 0 / decoder.
REQ-010 SHALL have port rd_data  output  32  register read data, 0 when not selected.
REQ-011 SHALL have port addr_hit  output  1  address falls in window and MemRead|MemWrite.
REQ-012 SHALL have port InterruptOut  output  1  drives coprocessor 0 interrupt input (cause bit 15).
REQ-013 SHALL have port active_id  output  3  index of source being asserted or serviced.

Function
REQ-014 SHALL latch irq_src each cycle; rising edge = irq_src & ~prev.
REQ-015 SHALL hold PENDING[N_SRC-1:0]; edge sets bit next cycle.
REQ-016 Register map: BASE+0 PENDING (R, write-1-to-clear), BASE+4 MASK (R/W, bits N_SRC-1:0), BASE+8 STATUS (R: {27'b0, state[1:0], active_id}); upper unused bits read 0, writes to STATUS ignored.
REQ-017 Reads combinational: rd_data valid same cycle as MemRead with matching address.
REQ-018 State machine IDLE, ASSERT, SERVICE.
REQ-019 IDLE: if (PENDING & MASK) != 0 -> ASSERT next cycle, active_id latched = lowest set index (index 0 highest priority).
REQ-020 ASSERT: InterruptOut = 1; on TakenInterrupt -> SERVICE and clear PENDING[active_id] same edge.
REQ-021 ASSERT: if software clears PENDING[active_id] or MASK[active_id] before TakenInterrupt -> IDLE, InterruptOut drops next cycle.
REQ-022 SERVICE: InterruptOut = 0; on ERET -> IDLE; new edges only accumulate in PENDING (no nesting).
REQ-023 InterruptOut SHALL be a registered output, 1 only in ASSERT.
REQ-024 Same-cycle edge set and W1C on same bit: set wins.
REQ-025 Same-cycle TakenInterrupt clear and new edge on active bit: bit ends set (re-pending).
REQ-026 ERET outside SERVICE SHALL be ignored; TakenInterrupt outside ASSERT SHALL be ignored.
REQ-027 Accesses with address[1:0] != 0 or outside BASE..BASE+8 SHALL not hit.

Reset
REQ-028 reset SHALL set PENDING=0, MASK=0, edge history=0, state=IDLE, active_id=0, InterruptOut=0; reset overrides all same-cycle events, including mid-ASSERT/SERVICE.
REQ-029 Edges present during the reset cycle SHALL be lost.

Structure
REQ-030 Shared package SHALL hold register offsets (0, 4, 8), state encodings (IDLE=0, ASSERT=1, SERVICE=2) and default BASE.
REQ-031 Single sub-module irq_prio_enc (N_SRC-in lowest-index priority encoder with valid flag) SHALL be used; all else inline.

Verification
REQ-032 Reset, MASK=4'b0101, pulse irq_src[2] -> PENDING=4'b0100, InterruptOut=1 two cycles after edge, active_id=2.
REQ-033 In ASSERT pulse TakenInterrupt -> next cycle STATUS state=2, PENDING[2]=0, InterruptOut=0; ERET -> state=0.
REQ-034 MASK=4'b1111, edges on 1 and 3 same cycle -> active_id=1; after Taken+ERET, active_id=3 asserted.
REQ-035 In ASSERT write 4'b0100 to BASE+0 before Taken -> state IDLE, InterruptOut=0 next cycle, no service.
REQ-036 Edge on bit 0 same cycle as W1C of bit 0 -> PENDING[0]=1; reset asserted in SERVICE -> all registers 0, state IDLE.
REQ-037 Read BASE+12 or BASE+2 -> addr_hit=0, rd_data=0; MASK write of 32'hFFFFFFFF reads back 32'h0000000F.
